// File: rtl/rv32i_defs.sv
// Shared definitions for the rv32i single-cycle core and its boot-time program loader.
package rv32i_defs;

   localparam int InstructionSize   = 32;
   localparam int LoaderHeaderBytes = 4;

   typedef enum logic [2:0] {
      LEN,
      DATA,
      CHECK,
      DONE,
      ERROR
   } loader_state_t;

   // Instruction memory capacity in words for a given byte-address width.
   function automatic int max_words(input int addr_size);
      return 2 ** (addr_size - 2);
   endfunction

endpackage

// File: rtl/byte_word_assembler.sv
// Packs a little-endian byte stream into 32-bit words; word/word_done are valid
// combinationally in the same cycle the fourth byte is strobed in.
module byte_word_assembler
   import rv32i_defs::*;
(
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       clear,
   input  logic                       byte_strobe,
   input  logic [7:0]                 byte_in,
   output logic [InstructionSize-1:0] word,
   output logic                       word_done
);

   localparam int CountWidth = $clog2(LoaderHeaderBytes);

   logic [CountWidth-1:0]      byte_count;
   logic [InstructionSize-1:0] shift_reg;

   // Newest byte enters at the top so the first byte ends up in bits [7:0].
   assign word      = {byte_in, shift_reg[InstructionSize-1:8]};
   assign word_done = byte_strobe && (byte_count == CountWidth'(LoaderHeaderBytes - 1));

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         byte_count <= '0;
         shift_reg  <= '0;
      end else if (byte_strobe) begin
         byte_count <= byte_count + 1'b1;
         shift_reg  <= word;
      end
   end

endmodule

// File: rtl/program_loader.sv
// Boot loader: streams a length-prefixed image into instruction memory, then releases core reset.
// Optional trailing XOR checksum gate selected by PROGRAM_LOADER_CHECKSUM_EN.
module program_loader
   import rv32i_defs::*;
#(
   parameter int AddrSize  = 10,
   parameter int CountSize = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       byte_valid,
   input  logic [7:0]                 byte_data,
   output logic                       byte_ready,
   output logic                       mem_write_enable,
   output logic [AddrSize-1:0]        mem_addr,
   output logic [InstructionSize-1:0] mem_write_data,
   output logic                       core_rst,
   output logic                       loaded,
   output logic                       error
);

   localparam int MaxWords   = max_words(AddrSize);
   localparam int IndexWidth = AddrSize - 1;

   loader_state_t              state;
   logic [IndexWidth-1:0]      word_index;
   logic [CountSize-1:0]       word_count;
   logic                       accept;
   logic                       asm_strobe;
   logic                       asm_clear;
   logic [InstructionSize-1:0] asm_word;
   logic                       asm_done;
   logic                       hdr_zero;
   logic                       hdr_bad;
   logic                       last_word;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
   logic [7:0]                 checksum;
`else
   logic                       last_write;
`endif

   assign accept     = byte_valid && byte_ready;
   assign asm_strobe = accept && ((state == LEN) || (state == DATA));
   assign asm_clear  = (state == DONE) || (state == ERROR);

   assign hdr_zero  = (asm_word == '0);
   assign hdr_bad   = ((asm_word >> CountSize) != '0) || (asm_word > InstructionSize'(MaxWords));
   assign last_word = (32'(word_index) + 32'd1) == 32'(word_count);

   byte_word_assembler u_assembler (
      .clk         (clk),
      .rst         (rst),
      .clear       (asm_clear),
      .byte_strobe (asm_strobe),
      .byte_in     (byte_data),
      .word        (asm_word),
      .word_done   (asm_done)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state            <= LEN;
         word_index       <= '0;
         word_count       <= '0;
         byte_ready       <= 1'b0;
         mem_write_enable <= 1'b0;
         mem_addr         <= '0;
         mem_write_data   <= '0;
         core_rst         <= 1'b1;
         loaded           <= 1'b0;
         error            <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
         checksum         <= '0;
`else
         last_write       <= 1'b0;
`endif
      end else begin
         mem_write_enable <= 1'b0;
         case (state)
            LEN: begin
               byte_ready <= 1'b1;
               if (asm_done) begin
                  if (hdr_zero) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                     state      <= CHECK;
`else
                     state      <= DONE;
                     core_rst   <= 1'b0;
                     loaded     <= 1'b1;
                     byte_ready <= 1'b0;
`endif
                  end else if (hdr_bad) begin
                     state      <= ERROR;
                     error      <= 1'b1;
                     byte_ready <= 1'b0;
                  end else begin
                     word_count <= asm_word[CountSize-1:0];
                     state      <= DATA;
                  end
               end
            end

            DATA: begin
               byte_ready <= 1'b1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
               if (asm_strobe) begin
                  checksum <= checksum ^ byte_data;
               end
`endif
               if (asm_done) begin
                  mem_write_enable <= 1'b1;
                  mem_addr         <= {word_index[IndexWidth-2:0], 2'b00};
                  mem_write_data   <= asm_word;
                  word_index       <= word_index + 1'b1;
                  if (last_word) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                     state <= CHECK;
`else
                     last_write <= 1'b1;
`endif
                  end
               end
`ifndef PROGRAM_LOADER_CHECKSUM_EN
               // Release waits one cycle so the final strobe is seen with the core still in reset.
               if (last_write) begin
                  last_write <= 1'b0;
                  state      <= DONE;
                  core_rst   <= 1'b0;
                  loaded     <= 1'b1;
                  byte_ready <= 1'b0;
               end
`endif
            end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
            CHECK: begin
               byte_ready <= 1'b1;
               if (accept) begin
                  byte_ready <= 1'b0;
                  if (byte_data == checksum) begin
                     state    <= DONE;
                     core_rst <= 1'b0;
                     loaded   <= 1'b1;
                  end else begin
                     state <= ERROR;
                     error <= 1'b1;
                  end
               end
            end
`endif

            DONE: begin
               byte_ready <= 1'b0;
               core_rst   <= 1'b0;
               loaded     <= 1'b1;
            end

            ERROR: begin
               byte_ready <= 1'b0;
               core_rst   <= 1'b1;
               loaded     <= 1'b0;
               error      <= 1'b1;
            end

            default: begin
               state      <= ERROR;
               error      <= 1'b1;
               byte_ready <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader; checksum cases run only with PROGRAM_LOADER_CHECKSUM_EN.
module tb_program_loader;

   logic        clk;
   logic        rst;
   logic        byte_valid;
   logic [7:0]  byte_data;
   logic        byte_ready;
   logic        mem_write_enable;
   logic [9:0]  mem_addr;
   logic [31:0] mem_write_data;
   logic        core_rst;
   logic        loaded;
   logic        error;

   int checks = 0;
   int errors = 0;

   int          wr_count = 0;
   logic [9:0]  wr_addr_log [8];
   logic [31:0] wr_data_log [8];
   int          base;

   program_loader #(.AddrSize(10), .CountSize(16)) dut (
      .clk              (clk),
      .rst              (rst),
      .byte_valid       (byte_valid),
      .byte_data        (byte_data),
      .byte_ready       (byte_ready),
      .mem_write_enable (mem_write_enable),
      .mem_addr         (mem_addr),
      .mem_write_data   (mem_write_data),
      .core_rst         (core_rst),
      .loaded           (loaded),
      .error            (error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (mem_write_enable) begin
         wr_addr_log[wr_count[2:0]] <= mem_addr;
         wr_data_log[wr_count[2:0]] <= mem_write_data;
         wr_count <= wr_count + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic send(input logic [7:0] b);
      logic acc;
      int   n;
      acc = 1'b0;
      n = 0;
      byte_valid = 1'b1;
      byte_data  = b;
      while (!acc && n < 50) begin
         acc = byte_ready;
         @(negedge clk);
         n++;
      end
      byte_valid = 1'b0;
      if (!acc) begin
         errors++;
         $error("FAIL send_timeout: byte %0h not accepted within 50 cycles", b);
      end
   endtask

   task automatic send_gapped(input logic [7:0] b);
      send(b);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      byte_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      base = wr_count;
   endtask

   initial begin
      rst = 1'b1;
      byte_valid = 1'b0;
      byte_data = 8'h00;
      repeat (2) @(negedge clk);

      // Reset state
      check("rst_byte_ready", 32'(byte_ready), 32'd0);
      check("rst_mem_we", 32'(mem_write_enable), 32'd0);
      check("rst_mem_addr", 32'(mem_addr), 32'd0);
      check("rst_mem_data", mem_write_data, 32'd0);
      check("rst_core_rst", 32'(core_rst), 32'd1);
      check("rst_loaded", 32'(loaded), 32'd0);
      check("rst_error", 32'(error), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("ready_after_rst", 32'(byte_ready), 32'd1);
      base = wr_count;

      // Two-word image, back to back
      send(8'h02); send(8'h00); send(8'h00); send(8'h00);
      send(8'h13); send(8'h00); send(8'h00); send(8'h00);
      check("w0_strobe", 32'(mem_write_enable), 32'd1);
      check("w0_addr", 32'(mem_addr), 32'h000);
      check("w0_data", mem_write_data, 32'h00000013);
      send(8'h6F); send(8'h00); send(8'h00); send(8'h00);
      check("w1_strobe", 32'(mem_write_enable), 32'd1);
      check("w1_addr", 32'(mem_addr), 32'h004);
      check("w1_data", mem_write_data, 32'h0000006F);
      check("w1_core_rst_held", 32'(core_rst), 32'd1);
      @(negedge clk);
      check("w2_core_rst_fall", 32'(core_rst), 32'd0);
      check("w2_loaded", 32'(loaded), 32'd1);
      check("w2_ready_low", 32'(byte_ready), 32'd0);
      check("w2_no_strobe", 32'(mem_write_enable), 32'd0);
      byte_valid = 1'b1;
      byte_data = 8'hAA;
      repeat (4) @(negedge clk);
      byte_valid = 1'b0;
      check("w2_write_count", 32'(wr_count - base), 32'd2);
      check("w2_log0", wr_data_log[base[2:0]], 32'h00000013);
      check("w2_still_loaded", 32'(loaded), 32'd1);

      // Empty image
      do_reset();
      send(8'h00); send(8'h00); send(8'h00); send(8'h00);
`ifndef PROGRAM_LOADER_CHECKSUM_EN
      check("n0_loaded", 32'(loaded), 32'd1);
      check("n0_core_rst", 32'(core_rst), 32'd0);
      check("n0_ready", 32'(byte_ready), 32'd0);
`endif
      check("n0_no_strobe", 32'(mem_write_enable), 32'd0);
      @(negedge clk);
      check("n0_write_count", 32'(wr_count - base), 32'd0);

      // Oversize image: 257 words
      do_reset();
      send(8'h01); send(8'h01); send(8'h00); send(8'h00);
      check("big_error", 32'(error), 32'd1);
      check("big_ready", 32'(byte_ready), 32'd0);
      check("big_core_rst", 32'(core_rst), 32'd1);
      check("big_loaded", 32'(loaded), 32'd0);
      repeat (3) @(negedge clk);
      check("big_error_sticky", 32'(error), 32'd1);
      check("big_write_count", 32'(wr_count - base), 32'd0);

      // High header bit set beyond the honoured count width
      do_reset();
      send(8'h01); send(8'h00); send(8'h01); send(8'h00);
      check("hibit_error", 32'(error), 32'd1);

      // One-word image with valid toggling
      do_reset();
      send_gapped(8'h01); send_gapped(8'h00); send_gapped(8'h00); send_gapped(8'h00);
      send_gapped(8'hEF); send_gapped(8'hBE); send_gapped(8'hAD);
      send(8'hDE);
      check("gap_strobe", 32'(mem_write_enable), 32'd1);
      check("gap_addr", 32'(mem_addr), 32'h000);
      check("gap_data", mem_write_data, 32'hDEADBEEF);
      @(negedge clk);
      check("gap_no_extra_strobe", 32'(mem_write_enable), 32'd0);
`ifndef PROGRAM_LOADER_CHECKSUM_EN
      check("gap_loaded", 32'(loaded), 32'd1);
`endif
      @(negedge clk);
      check("gap_write_count", 32'(wr_count - base), 32'd1);

      // Reset in the middle of a three-word image
      do_reset();
      send(8'h03); send(8'h00); send(8'h00); send(8'h00);
      send(8'h11); send(8'h22);
      rst = 1'b1;
      @(negedge clk);
      check("mid_ready", 32'(byte_ready), 32'd0);
      check("mid_mem_we", 32'(mem_write_enable), 32'd0);
      check("mid_addr", 32'(mem_addr), 32'd0);
      check("mid_data", mem_write_data, 32'd0);
      check("mid_core_rst", 32'(core_rst), 32'd1);
      check("mid_loaded", 32'(loaded), 32'd0);
      check("mid_error", 32'(error), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      base = wr_count;
      send(8'h01); send(8'h00); send(8'h00); send(8'h00);
      send(8'h78); send(8'h56); send(8'h34); send(8'h12);
      check("mid_reload_addr", 32'(mem_addr), 32'h000);
      check("mid_reload_data", mem_write_data, 32'h12345678);
      @(negedge clk);
`ifndef PROGRAM_LOADER_CHECKSUM_EN
      check("mid_reload_loaded", 32'(loaded), 32'd1);
      check("mid_reload_core_rst", 32'(core_rst), 32'd0);
`endif
      @(negedge clk);
      check("mid_reload_count", 32'(wr_count - base), 32'd1);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
      // Checksum match
      do_reset();
      send(8'h01); send(8'h00); send(8'h00); send(8'h00);
      send(8'h13); send(8'h00); send(8'h00); send(8'h00);
      send(8'h13);
      check("cs_ok_loaded", 32'(loaded), 32'd1);
      check("cs_ok_error", 32'(error), 32'd0);

      // Checksum mismatch: write still happened
      do_reset();
      send(8'h01); send(8'h00); send(8'h00); send(8'h00);
      send(8'h13); send(8'h00); send(8'h00); send(8'h00);
      send(8'h12);
      check("cs_bad_error", 32'(error), 32'd1);
      check("cs_bad_core_rst", 32'(core_rst), 32'd1);
      @(negedge clk);
      check("cs_bad_write_count", 32'(wr_count - base), 32'd1);
      check("cs_bad_write_data", wr_data_log[base[2:0]], 32'h00000013);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Upstream boot stage for the single-cycle core's instruction memory.
- Receives a byte stream over a valid/ready handshake, assembles little-endian 32-bit words and writes them sequentially into instruction memory from byte address 0.
- Holds the core in reset until the whole image is written, then releases it.
- Sits between the host byte source (UART receiver) and the instruction memory write port / core reset.

Parameters:
- AddrSize, 10, instruction memory byte-address width; capacity MaxWords = 2**(AddrSize-2).
- CountSize, 16, width of the word-count header field actually honoured; header bits above CountSize must be zero.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- byte_valid  input  1  byte_data is valid this cycle
- byte_data  input  8  incoming stream byte
- byte_ready  output  1  loader accepts a byte this cycle; a transfer happens when byte_valid && byte_ready
- mem_write_enable  output  1  instruction memory write strobe, one cycle per word
- mem_addr  output  AddrSize  byte address of the word being written, always word aligned
- mem_write_data  output  32  word being written
- core_rst  output  1  reset to the datapath; high until the load completes
- loaded  output  1  image fully written, core running
- error  output  1  load aborted; sticky until rst

Behaviour:
- Reset values:
  - byte_ready=0, mem_write_enable=0, mem_addr=0, mem_write_data=0.
  - core_rst=1, loaded=0, error=0.
  - State LEN; byte counter, word index and count are all 0.
- byte_ready is registered.
  - It is 1 in LEN and DATA (and CHECK when the optional feature is enabled) from the first cycle after reset deasserts.
  - It is 0 in DONE and ERROR.
- Stream format: 4-byte little-endian word count N, then N words of 4 bytes each, each word little-endian (first byte becomes bits [7:0]).
- LEN state:
  - Collect 4 bytes.
  - On acceptance of the 4th byte:
    - N==0: go to DONE.
    - N>MaxWords, or any header bit >= CountSize set: go to ERROR.
    - Otherwise: go to DATA.
- DATA state:
  - A 2-bit byte counter shifts each accepted byte into a word register.
  - On acceptance of the 4th byte, in the next cycle:
    - mem_write_enable=1 for exactly one cycle.
    - mem_addr = word_index*4.
    - mem_write_data = assembled word.
  - word_index increments after the write.
  - Bytes are accepted back-to-back with no bubbles; the write of word k overlaps reception of word k+1.
  - After the write of word N-1, go to DONE.
- DONE state:
  - core_rst falls to 0 and loaded rises to 1 in the cycle after the final write strobe.
  - This is also the first cycle of DONE: for N==0, the cycle after the 4th header byte.
  - All further bytes are ignored (byte_ready=0).
- ERROR state: error=1, core_rst=1, loaded=0, byte_ready=0. Exit only by rst.
- byte_valid low stalls all counters; no timeout.
- rst mid-load:
  - Next cycle returns to the full reset state.
  - Any pending write strobe is suppressed.
  - Partially written memory is not cleared.
- word_index never wraps: the N<=MaxWords check guarantees word_index < MaxWords.

Optional Feature:
- Macro: PROGRAM_LOADER_CHECKSUM_EN.
- Defined:
  - The stream carries one trailing byte equal to the XOR of all payload bytes; header bytes are excluded, and the XOR is 0x00 when N==0.
  - After the last word (or directly after the header when N==0), go to CHECK.
  - On acceptance of the checksum byte: match goes to DONE, mismatch goes to ERROR.
  - Memory writes still happen before the check; only core release is gated.
- Undefined: no CHECK state, no checksum register; behaviour is exactly as described above.

Decomposition:
- Shared package rv32i_defs gains:
  - loader_state_t enum {LEN, DATA, CHECK, DONE, ERROR}.
  - Constant LoaderHeaderBytes = 4.
  - Reuses the existing InstructionSize for the 32-bit word width.
- One sub-module, byte_word_assembler:
  - Inputs: clk, rst, clear, byte strobe + byte.
  - Outputs: 32-bit word, word_done pulse.
  - Used for both the header and payload words.

Test Plan:
- Stream 02 00 00 00 | 13 00 00 00 | 6F 00 00 00, valid every cycle:
  - writes addr 0x000 = 0x00000013, then addr 0x004 = 0x0000006F.
  - core_rst falls the cycle after the second strobe; loaded=1.
- Header 00 00 00 00: no write strobe; DONE the cycle after the 4th byte; core_rst=0.
- Header N=MaxWords+1 (AddrSize=10 gives 257 = 01 01 00 00): error=1, byte_ready=0, core_rst stays 1, no writes.
- One-word image with byte_valid toggling 1/0 every cycle: single write of 0xDEADBEEF from bytes EF BE AD DE; no extra strobes during gaps.
- Assert rst after the 2nd payload byte of a 3-word image: all outputs return to reset values; a fresh 1-word stream then loads to addr 0 correctly.
- With PROGRAM_LOADER_CHECKSUM_EN, 1-word stream 13 00 00 00:
  - checksum 13 gives DONE.
  - checksum 12 gives ERROR, with the write to addr 0 still having occurred.
